// File: rtl/kamus_ctrl.sv
// kamus_ctrl: multi-cycle control FSM for a small RISC-V core (fetch/decode/exec/mem/trap).
// Optional bus-timeout trap enabled by defining KAMUS_BUS_TIMEOUT_EN.
package kamus_pkg;
  typedef enum logic [4:0] {
    OP_INVALID = 5'd0,
    OP_LUI     = 5'd1,
    OP_AUIPC   = 5'd2,
    OP_JAL     = 5'd3,
    OP_JALR    = 5'd4,
    OP_BEQ     = 5'd5,
    OP_BNE     = 5'd6,
    OP_BLT     = 5'd7,
    OP_BGE     = 5'd8,
    OP_BLTU    = 5'd9,
    OP_BGEU    = 5'd10,
    OP_LOAD    = 5'd11,
    OP_STORE   = 5'd12,
    OP_ADD     = 5'd13,
    OP_SUB     = 5'd14,
    OP_AND     = 5'd15,
    OP_OR      = 5'd16,
    OP_XOR     = 5'd17,
    OP_SLL     = 5'd18,
    OP_SRL     = 5'd19,
    OP_SRA     = 5'd20,
    OP_SLT     = 5'd21,
    OP_SLTU    = 5'd22,
    OP_FENCE   = 5'd23,
    OP_FENCE_I = 5'd24,
    OP_ECALL   = 5'd25,
    OP_EBREAK  = 5'd26
  } operation_e;
endpackage

module kamus_ctrl
  import kamus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  output logic       instr_req_o,
  input  logic       instr_gnt_i,
  input  logic       instr_rvalid_i,
  input  operation_e operation_i,
  input  logic       immediate_used_i,
  input  logic       branch_taken_i,
  output logic       data_req_o,
  output logic       data_we_o,
  input  logic       data_gnt_i,
  input  logic       data_rvalid_i,
  output logic       ir_we_o,
  output logic       pc_we_o,
  output logic [1:0] pc_sel_o,
  output logic       rf_we_o,
  output logic       alu_b_imm_o,
  output logic       trap_o,
  output logic [3:0] trap_cause_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_WAIT_I = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WAIT_D = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  generate
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES out of range 2..255");
    end
  endgenerate

  state_e      state_r, state_nxt_s;
  logic [3:0]  cause_r, cause_nxt_s;
  logic        is_store_r, is_store_nxt_s;

  logic        instr_req_s, data_req_s, data_we_s, ir_we_s, pc_we_s;
  logic [1:0]  pc_sel_s;
  logic        rf_we_s, alu_b_imm_s, trap_s;
  logic [3:0]  trap_cause_s;
  logic        timeout_s;

`ifdef KAMUS_BUS_TIMEOUT_EN
  logic [7:0] cnt_r;
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  // Wait-cycle counter: cleared on entry to a wait state, counts while waiting.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_r <= 8'd0;
    end else if ((state_nxt_s == S_WAIT_I || state_nxt_s == S_WAIT_D) && state_nxt_s != state_r) begin
      cnt_r <= 8'd0;
    end else if (state_r == S_WAIT_I || state_r == S_WAIT_D) begin
      cnt_r <= cnt_r + 8'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign timeout_s = (cnt_r == TIMEOUT_LAST);
`else
  assign timeout_s = 1'b0;
`endif

  // State, trap cause and latched memory direction.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r    <= S_FETCH;
      cause_r    <= 4'd0;
      is_store_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cause_r    <= cause_nxt_s;
      is_store_r <= is_store_nxt_s;
    end
  end

  // Next-state and per-state strobes; operation_i is only looked at in DECODE/EXEC.
  always_comb begin
    state_nxt_s    = state_r;
    cause_nxt_s    = cause_r;
    is_store_nxt_s = is_store_r;
    instr_req_s    = 1'b0;
    data_req_s     = 1'b0;
    data_we_s      = 1'b0;
    ir_we_s        = 1'b0;
    pc_we_s        = 1'b0;
    pc_sel_s       = 2'b00;
    rf_we_s        = 1'b0;
    alu_b_imm_s    = 1'b0;
    trap_s         = 1'b0;
    trap_cause_s   = 4'd0;
    case (state_r)
      S_FETCH: begin
        instr_req_s = 1'b1;
        if (instr_gnt_i) begin
          state_nxt_s = S_WAIT_I;
        end else begin
          state_nxt_s = S_FETCH;
        end
      end
      S_WAIT_I: begin
        if (instr_rvalid_i) begin
          ir_we_s     = 1'b1;
          state_nxt_s = S_DECODE;
        end else if (timeout_s) begin
          cause_nxt_s = 4'd1;
          state_nxt_s = S_TRAP;
        end else begin
          state_nxt_s = S_WAIT_I;
        end
      end
      S_DECODE: begin
        case (operation_i)
          OP_INVALID: begin cause_nxt_s = 4'd2;  state_nxt_s = S_TRAP; end
          OP_ECALL:   begin cause_nxt_s = 4'd11; state_nxt_s = S_TRAP; end
          OP_EBREAK:  begin cause_nxt_s = 4'd3;  state_nxt_s = S_TRAP; end
          default:    state_nxt_s = S_EXEC;
        endcase
      end
      S_EXEC: begin
        alu_b_imm_s = immediate_used_i;
        state_nxt_s = S_FETCH;
        case (operation_i)
          OP_LOAD, OP_STORE: begin
            is_store_nxt_s = (operation_i == OP_STORE);
            state_nxt_s    = S_MEM;
          end
          OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
            pc_we_s  = 1'b1;
            pc_sel_s = branch_taken_i ? 2'b01 : 2'b00;
          end
          OP_JAL, OP_JALR: begin
            rf_we_s  = 1'b1;
            pc_we_s  = 1'b1;
            pc_sel_s = 2'b01;
          end
          OP_FENCE, OP_FENCE_I: begin
            pc_we_s = 1'b1;
          end
          default: begin
            rf_we_s = 1'b1;
            pc_we_s = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        data_req_s = 1'b1;
        data_we_s  = is_store_r;
        if (data_gnt_i) begin
          state_nxt_s = S_WAIT_D;
        end else begin
          state_nxt_s = S_MEM;
        end
      end
      S_WAIT_D: begin
        if (data_rvalid_i) begin
          pc_we_s     = 1'b1;
          rf_we_s     = ~is_store_r;
          state_nxt_s = S_FETCH;
        end else if (timeout_s) begin
          cause_nxt_s = is_store_r ? 4'd7 : 4'd5;
          state_nxt_s = S_TRAP;
        end else begin
          state_nxt_s = S_WAIT_D;
        end
      end
      S_TRAP: begin
        trap_s       = 1'b1;
        trap_cause_s = cause_r;
        pc_we_s      = 1'b1;
        pc_sel_s     = 2'b10;
        state_nxt_s  = S_FETCH;
      end
      default: begin
        state_nxt_s = S_FETCH;
      end
    endcase
  end

  // Outputs are forced low while reset is held, without waiting for a clock.
  assign instr_req_o  = instr_req_s & ~rst_i;
  assign data_req_o   = data_req_s & ~rst_i;
  assign data_we_o    = data_we_s & ~rst_i;
  assign ir_we_o      = ir_we_s & ~rst_i;
  assign pc_we_o      = pc_we_s & ~rst_i;
  assign pc_sel_o     = rst_i ? 2'b00 : pc_sel_s;
  assign rf_we_o      = rf_we_s & ~rst_i;
  assign alu_b_imm_o  = alu_b_imm_s & ~rst_i;
  assign trap_o       = trap_s & ~rst_i;
  assign trap_cause_o = rst_i ? 4'd0 : trap_cause_s;
  assign state_o      = state_r;

endmodule

// File: doc/kamus_ctrl.md
KAMUS_CTRL -- requirements
Module: kamus_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning max cycles waited for rvalid after grant before a bus-fault trap (range 2..255).
REQ-002 SHALL have ports, in order:
  clk_i  in  1  single clock, all state on rising edge
  rst_i  in  1  reset, asynchronous, active-high
  instr_req_o  out  1  instruction fetch request
  instr_gnt_i  in  1  fetch request accepted
  instr_rvalid_i  in  1  fetch data valid
  operation_i  in  operation_e  decoded operation (kamus_pkg)
  immediate_used_i  in  1  decoder immediate-used flag
  branch_taken_i  in  1  ALU compare result
  data_req_o  out  1  data memory request
  data_we_o  out  1  data request is a store
  data_gnt_i  in  1  data request accepted
  data_rvalid_i  in  1  data response valid
  ir_we_o  out  1  load instruction register
  pc_we_o  out  1  update PC
  pc_sel_o  out  2  00 PC+4, 01 jump/branch target, 10 trap vector
  rf_we_o  out  1  register-file write enable
  alu_b_imm_o  out  1  ALU operand B selects immediate
  trap_o  out  1  trap taken (1-cycle pulse)
  trap_cause_o  out  4  mcause code, valid while trap_o=1
  state_o  out  3  current FSM state (debug)

Function
REQ-003 SHALL implement FSM states FETCH(0), WAIT_I(1), DECODE(2), EXEC(3), MEM(4), WAIT_D(5), TRAP(6); state_o SHALL equal the encoding.
REQ-004 FETCH: instr_req_o=1; on instr_gnt_i -> WAIT_I, else stay.
REQ-005 WAIT_I: on instr_rvalid_i, ir_we_o=1 that cycle -> DECODE; rvalid in the grant cycle SHALL be ignored.
REQ-006 DECODE (1 cycle): INVALID -> TRAP cause 2; ECALL -> TRAP cause 11; EBREAK -> TRAP cause 3; else -> EXEC.
REQ-007 EXEC (1 cycle): alu_b_imm_o=immediate_used_i; LOAD/STORE -> MEM with no other strobes.
REQ-008 EXEC branches: pc_we_o=1, pc_sel_o=01 if branch_taken_i else 00, rf_we_o=0 -> FETCH.
REQ-009 EXEC JAL/JALR: rf_we_o=1, pc_we_o=1, pc_sel_o=01 -> FETCH.
REQ-010 EXEC FENCE/FENCE_I: pc_we_o=1, pc_sel_o=00, rf_we_o=0; all other ops: rf_we_o=1, pc_we_o=1, pc_sel_o=00 -> FETCH.
REQ-011 MEM: data_req_o=1, data_we_o=1 iff STORE; operation latched at EXEC exit; on data_gnt_i -> WAIT_D.
REQ-012 WAIT_D: on data_rvalid_i, pc_we_o=1, pc_sel_o=00, rf_we_o=1 iff LOAD -> FETCH.
REQ-013 TRAP (1 cycle): trap_o=1, trap_cause_o=latched cause, pc_we_o=1, pc_sel_o=10 -> FETCH.
REQ-014 Every strobe (ir_we_o, pc_we_o, rf_we_o, trap_o) SHALL be asserted for exactly one cycle per event; outputs not listed for a state SHALL be 0.
REQ-015 Requests SHALL hold high until granted; operation_i/branch_taken_i SHALL be sampled only in the state that uses them.

Reset
REQ-016 rst_i high SHALL immediately force state FETCH, cause 0, timeout counter 0, all outputs 0 except instr_req_o (1 once rst_i deasserts, registered-state driven).
REQ-017 Reset mid-transaction SHALL abandon it; late rvalid after reset SHALL be ignored in FETCH.

Configuration
REQ-018 With KAMUS_BUS_TIMEOUT_EN defined: 8-bit counter clears on entering WAIT_I/WAIT_D, increments each waiting cycle; reaching TIMEOUT_CYCLES without rvalid -> TRAP, cause 1 (WAIT_I), 5 (WAIT_D load), 7 (WAIT_D store); rvalid on the expiry cycle wins over timeout.
REQ-019 Without KAMUS_BUS_TIMEOUT_EN: no counter is synthesized; WAIT states wait indefinitely; causes 1/5/7 never produced.

Verification
REQ-020 ADD, gnt/rvalid each 1 cycle later -> states 0,1,2,3,0; ir_we_o in WAIT_I, rf_we_o+pc_we_o sel 00 in EXEC; 5 cycles per instr.
REQ-021 BEQ taken then BNE not taken -> pc_sel_o 01 then 00, rf_we_o=0 both.
REQ-022 LOAD, data_gnt_i after 2 cycles, rvalid after 3 -> data_req_o held 3 cycles, rf_we_o single pulse with rvalid, data_we_o=0.
REQ-023 INVALID then ECALL -> trap_o pulses with cause 2 then 11, pc_sel_o=10, no rf_we_o.
REQ-024 KAMUS_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=16, STORE with no rvalid -> trap cause 7 exactly 16 cycles after grant; rvalid on cycle 16 -> no trap.
REQ-025 rst_i asserted during WAIT_D -> outputs 0 same cycle, FETCH after release, stray data_rvalid_i ignored.
